// File: rtl/sine_lut_arbiter.sv
// Round-robin sharing of one quarter-wave sine ROM between NUM_REQ channels, with full-wave rebuild.
// Optional macro SINE_ARB_FIXED_PRI_EN selects fixed lowest-index-wins priority instead of round-robin.
module sine_lut_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 7,
  parameter int ROM_W   = 9,
  parameter int OUT_W   = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*(IDX_W+2)-1:0]       phase,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [IDX_W-1:0]                   rom_addr,
  input  logic [ROM_W-1:0]                   rom_data,
  output logic                               rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic [OUT_W-1:0]                   rsp_sample
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PH_W = IDX_W + 2;

  // Odd quadrants read the quarter wave backwards; (2**IDX_W-1) - idx is the bitwise complement.
  function automatic logic [IDX_W-1:0] mirror_idx(input logic [1:0] quad, input logic [IDX_W-1:0] idx);
    mirror_idx = quad[0] ? ~idx : idx;
  endfunction

  function automatic logic [OUT_W-1:0] rebuild_sample(input logic neg, input logic [ROM_W-1:0] mag);
    logic [OUT_W-1:0] mid;
    logic [OUT_W-1:0] mag_x;
    mid   = OUT_W'(1) << ROM_W;
    mag_x = OUT_W'(mag);
    rebuild_sample = neg ? (mid - mag_x) : (mid + mag_x);
  endfunction

  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [PH_W-1:0] phase_sel;
  int              scan_j;

`ifndef SINE_ARB_FIXED_PRI_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
`endif

  // Stage p0: arbitration and phase select (combinational)
  always_comb begin
    gnt       = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    phase_sel = '0;
    scan_j    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SINE_ARB_FIXED_PRI_EN
      scan_j = k;
`else
      scan_j = int'(ptr_q) + k;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
`endif
      if (!gnt_any && req[scan_j]) begin
        gnt_any        = 1'b1;
        gnt[scan_j]    = 1'b1;
        gnt_idx        = ID_W'(scan_j);
        phase_sel      = phase[scan_j*PH_W +: PH_W];
      end
    end
  end

`ifndef SINE_ARB_FIXED_PRI_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Stage p1: ROM address, sign and owner of the lookup in flight
  logic [IDX_W-1:0] addr_p1_q, addr_p1_d;
  logic             neg_p1_q, neg_p1_d;
  logic [ID_W-1:0]  id_p1_q, id_p1_d;
  logic             vld_p1_q;

  always_comb begin
    addr_p1_d = addr_p1_q;
    neg_p1_d  = neg_p1_q;
    id_p1_d   = id_p1_q;
    if (gnt_any) begin
      addr_p1_d = mirror_idx(phase_sel[PH_W-1 -: 2], phase_sel[IDX_W-1:0]);
      neg_p1_d  = phase_sel[PH_W-1];
      id_p1_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p1_q <= '0;
      neg_p1_q  <= 1'b0;
      id_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      addr_p1_q <= addr_p1_d;
      neg_p1_q  <= neg_p1_d;
      id_p1_q   <= id_p1_d;
      vld_p1_q  <= gnt_any;
    end
  end

  assign rom_addr = addr_p1_q;

  // Stage p2: rebuild full-wave sample from ROM magnitude
  logic [OUT_W-1:0] sample_p2_q, sample_p2_d;
  logic [ID_W-1:0]  id_p2_q, id_p2_d;
  logic             vld_p2_q;

  always_comb begin
    sample_p2_d = sample_p2_q;
    id_p2_d     = id_p2_q;
    if (vld_p1_q) begin
      sample_p2_d = rebuild_sample(neg_p1_q, rom_data);
      id_p2_d     = id_p1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_p2_q <= '0;
      id_p2_q     <= '0;
      vld_p2_q    <= 1'b0;
    end else begin
      sample_p2_q <= sample_p2_d;
      id_p2_q     <= id_p2_d;
      vld_p2_q    <= vld_p1_q;
    end
  end

  assign rsp_valid  = vld_p2_q;
  assign rsp_id     = id_p2_q;
  assign rsp_sample = sample_p2_q;

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Directed bench for sine_lut_arbiter; honours SINE_ARB_FIXED_PRI_EN for arbitration expectations.
module tb_sine_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [17:0] phase;
  logic [1:0]  gnt;
  logic [6:0]  rom_addr;
  logic [8:0]  rom_data;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [9:0]  rsp_sample;

  logic        ovr_en;
  logic [8:0]  ovr_val;
  int          errors = 0;
  int          checks = 0;

`ifdef SINE_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  always #5 clk = ~clk;

  // ROM stand-in: either a forced value or the address itself as magnitude
  assign rom_data = ovr_en ? ovr_val : {2'b00, rom_addr};

  sine_lut_arbiter #(.NUM_REQ(2), .IDX_W(7), .ROM_W(9), .OUT_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .phase      (phase),
    .gnt        (gnt),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sample (rsp_sample)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; phase = '0; ovr_en = 1'b0; ovr_val = '0;
    #17;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_sample !== 10'd0) begin errors++; $display("FAIL reset_rsp_sample got=%0d exp=0", rsp_sample); end
    checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 2'b01; phase = {9'd0, 2'd0, 7'd5}; ovr_en = 1'b1; ovr_val = 9'h0A0;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    tick(); req = 2'b00;
    checks++; if (rom_addr !== 7'd5) begin errors++; $display("FAIL single_rom_addr got=%0d exp=5", rom_addr); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_sample !== 10'd672) begin errors++; $display("FAIL single_rsp_sample got=%0d exp=672", rsp_sample); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_bubble_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_sample !== 10'd672) begin errors++; $display("FAIL single_hold_sample got=%0d exp=672", rsp_sample); end
  endtask

  task automatic test_mirror();
    req = 2'b10; phase = {2'd1, 7'd0, 9'd0}; ovr_en = 1'b1; ovr_val = 9'd100;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mirror_gnt got=%b exp=10", gnt); end
    tick(); req = 2'b00;
    checks++; if (rom_addr !== 7'd127) begin errors++; $display("FAIL mirror_q1_addr got=%0d exp=127", rom_addr); end
    tick(); tick();
    req = 2'b10; phase = {2'd3, 7'd10, 9'd0};
    tick(); req = 2'b00;
    checks++; if (rom_addr !== 7'd117) begin errors++; $display("FAIL mirror_q3_addr got=%0d exp=117", rom_addr); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mirror_q3_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL mirror_q3_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_sample !== 10'd412) begin errors++; $display("FAIL mirror_q3_sample got=%0d exp=412", rsp_sample); end
    tick();
  endtask

  task automatic test_extremes();
    logic [1:0] quads [3] = '{2'd0, 2'd2, 2'd2};
    logic [8:0] romv  [3] = '{9'd511, 9'd511, 9'd0};
    logic [9:0] exps  [3] = '{10'd1023, 10'd1, 10'd512};
    for (int v = 0; v < 3; v++) begin
      req = 2'b01; phase = {9'd0, quads[v], 7'd33}; ovr_en = 1'b1; ovr_val = romv[v];
      tick(); req = 2'b00;
      checks++; if (rom_addr !== 7'd33) begin errors++; $display("FAIL extreme%0d_addr got=%0d exp=33", v, rom_addr); end
      tick();
      checks++; if (rsp_sample !== exps[v]) begin errors++; $display("FAIL extreme%0d_sample got=%0d exp=%0d", v, rsp_sample, exps[v]); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL extreme%0d_valid got=%0b exp=1", v, rsp_valid); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt;
    logic [0:0] exp_id;
    logic [9:0] exp_smp;
    rst = 1'b1; #2; rst = 1'b0;
    ovr_en = 1'b0;
    phase = {2'd2, 7'd30, 2'd0, 7'd20};
    for (int c = 0; c < 8; c++) begin
      req = (c < 6) ? 2'b11 : 2'b00;
      #1;
      exp_gnt = (c >= 6) ? 2'b00 : (FIXED ? 2'b01 : ((c % 2) ? 2'b10 : 2'b01));
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (c >= 2) begin
        exp_id  = FIXED ? 1'b0 : 1'((c - 2) % 2);
        exp_smp = (exp_id == 1'b1) ? 10'd482 : 10'd532;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d got=%0b exp=1", c, rsp_valid); end
        checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL b2b_id c=%0d got=%0d exp=%0d", c, rsp_id, exp_id); end
        checks++; if (rsp_sample !== exp_smp) begin errors++; $display("FAIL b2b_sample c=%0d got=%0d exp=%0d", c, rsp_sample, exp_smp); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d got=%0b exp=0", c, rsp_valid); end
      end
      tick();
    end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_rst_midstream();
    ovr_en = 1'b0;
    phase = {2'd2, 7'd30, 2'd0, 7'd20};
    req = 2'b11;
    tick(); tick(); tick();
    #1;
    checks++; if (gnt !== (FIXED ? 2'b01 : 2'b10)) begin errors++; $display("FAIL midrst_pre_gnt got=%b exp=%b", gnt, FIXED ? 2'b01 : 2'b10); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rom_addr !== 7'd20) begin errors++; $display("FAIL midrst_pre_addr got=%0d exp=20", rom_addr); end
    #1; rst = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL midrst_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_sample !== 10'd0) begin errors++; $display("FAIL midrst_sample got=%0d exp=0", rsp_sample); end
    checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL midrst_addr got=%0d exp=0", rom_addr); end
    #1; rst = 1'b0; #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_first_gnt got=%b exp=01", gnt); end
    tick(); req = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_rst_pipeline();
    req = 2'b01; phase = {9'd0, 2'd0, 7'd40}; ovr_en = 1'b1; ovr_val = 9'd200;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL pipe_gnt got=%b exp=01", gnt); end
    tick(); req = 2'b00;
    checks++; if (rom_addr !== 7'd40) begin errors++; $display("FAIL pipe_addr got=%0d exp=40", rom_addr); end
    #2; rst = 1'b1; #2; rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pipe_dropped_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_sample !== 10'd0) begin errors++; $display("FAIL pipe_dropped_sample got=%0d exp=0", rsp_sample); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pipe_late_valid got=%0b exp=0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mirror();
    test_extremes();
    test_back_to_back();
    test_rst_midstream();
    test_rst_pipeline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
